// File: rtl/sram_rq_responder_if.sv
// Request channel between an sram_itf initiator and the SRAM responder.
interface sram_rq_responder_if #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 32
);
  logic          rq_valid_i;
  logic          rq_wr_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wr_data_i;
  logic          rq_ready_o;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          busy_o;

  modport master (
    output rq_valid_i, rq_wr_i, addr_i, wr_data_i,
    input  rq_ready_o, rd_valid_o, rd_data_o, busy_o
  );

  modport slave (
    input  rq_valid_i, rq_wr_i, addr_i, wr_data_i,
    output rq_ready_o, rd_valid_o, rd_data_o, busy_o
  );
endinterface

// File: rtl/sram_rq_responder.sv
// Sequences analog SRAM macro controls for single-word read/write requests
// and returns sensed read data with a one-cycle rd_valid pulse.
module sram_rq_responder #(
  parameter int unsigned numRows    = 128,
  parameter int unsigned numCols    = 32,
  parameter int unsigned PCH_CYCLES = 2,
  parameter int unsigned WL_CYCLES  = 1,
  parameter int unsigned SA_CYCLES  = 2,
  parameter int unsigned WR_CYCLES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mac_busy_i,
  sram_rq_responder_if.slave  rq,
  output logic [numRows-1:0]  WL,
  output logic                PCH,
  output logic                WRITE,
  output logic [numCols-1:0]  WR_DATA,
  output logic [numCols-1:0]  CSEL,
  output logic                SAEN,
  input  logic [numCols-1:0]  SA_OUT
);

  localparam int unsigned AW      = (numRows > 1) ? $clog2(numRows) : 1;
  localparam int unsigned MAX_A   = (PCH_CYCLES > WL_CYCLES) ? PCH_CYCLES : WL_CYCLES;
  localparam int unsigned MAX_B   = (SA_CYCLES > WR_CYCLES) ? SA_CYCLES : WR_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_REC,
    S_RD_PCH,
    S_RD_WL,
    S_RD_SA,
    S_RD_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [numCols-1:0]   data_q, data_d;
  logic [numCols-1:0]   rd_data_q, rd_data_d;
  logic [numRows-1:0]   wl_row_c;
  logic                 addr_ok_c;
  logic                 ready_c;
  logic                 cnt_done_c;

  // Out-of-range addresses shift the single bit out, leaving no wordline.
  assign wl_row_c   = numRows'(1) << addr_q;
  assign addr_ok_c  = |wl_row_c;
  assign ready_c    = (state_q == S_IDLE) & ~mac_busy_i;
  assign cnt_done_c = (cnt_q == '0);

  assign rq.rq_ready_o = ready_c;
  assign rq.rd_valid_o = (state_q == S_RD_RESP);
  assign rq.rd_data_o  = rd_data_q;
  assign rq.busy_o     = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Next state: one down-counter reloaded with (duration-1) on every state entry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_data_d = rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (rq.rq_valid_i && ready_c) begin
          addr_d = rq.addr_i;
          data_d = rq.wr_data_i;
          if (rq.rq_wr_i) begin
            state_d = S_WR;
            cnt_d   = CW'(WR_CYCLES - 1);
          end else begin
            state_d = S_RD_PCH;
            cnt_d   = CW'(PCH_CYCLES - 1);
          end
        end
      end
      S_WR: begin
        if (cnt_done_c) begin
          state_d = S_WR_REC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WR_REC: begin
        state_d = S_IDLE;
      end
      S_RD_PCH: begin
        if (cnt_done_c) begin
          state_d = S_RD_WL;
          cnt_d   = CW'(WL_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RD_WL: begin
        if (cnt_done_c) begin
          state_d = S_RD_SA;
          cnt_d   = CW'(SA_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RD_SA: begin
        if (cnt_done_c) begin
          state_d   = S_RD_RESP;
          cnt_d     = '0;
          rd_data_d = addr_ok_c ? SA_OUT : '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RD_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore decode of macro controls from registered state and latched request.
  always_comb begin
    WL      = '0;
    PCH     = 1'b0;
    WRITE   = 1'b0;
    WR_DATA = '0;
    CSEL    = '0;
    SAEN    = 1'b0;
    case (state_q)
      S_WR: begin
        WL      = wl_row_c;
        WRITE   = 1'b1;
        WR_DATA = data_q;
        CSEL    = '1;
      end
      S_RD_PCH: begin
        PCH  = 1'b1;
        CSEL = '1;
      end
      S_RD_WL: begin
        WL   = wl_row_c;
        CSEL = '1;
      end
      S_RD_SA: begin
        WL   = wl_row_c;
        SAEN = 1'b1;
        CSEL = '1;
      end
      default: begin
        WL = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_rq_responder.sv
// Self-checking bench for sram_rq_responder: directed table, corner sequences
// and randomized traffic against a behavioural macro and expected schedule.
module tb_sram_rq_responder;
  localparam int unsigned NR  = 128;
  localparam int unsigned NC  = 32;
  localparam int unsigned AWT = 7;
  localparam int unsigned PCH = 2;
  localparam int unsigned WLC = 1;
  localparam int unsigned SAC = 2;
  localparam int unsigned WRC = 2;

  typedef enum {P_IDLE, P_WR, P_REC, P_PCH, P_WL, P_SA, P_RESP} ph_t;

  typedef struct packed {
    logic [NR-1:0] wl;
    logic          pch;
    logic          write;
    logic [NC-1:0] wr_data;
    logic [NC-1:0] csel;
    logic          saen;
    logic          rd_valid;
    logic          busy;
    logic          ready;
  } ctl_t;

  typedef struct {
    bit        wr;
    logic [6:0]  a;
    logic [31:0] d;
    int          mb_pre;
    bit          mb_mid;
    logic [31:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic mac_busy;
  logic mem_clr;
  logic [NR-1:0] wl;
  logic pch, write, saen;
  logic [NC-1:0] wr_data, csel, sa_out;

  sram_rq_responder_if #(.AW(AWT), .DW(NC)) rq ();

  sram_rq_responder #(
    .numRows(NR), .numCols(NC), .PCH_CYCLES(PCH), .WL_CYCLES(WLC),
    .SA_CYCLES(SAC), .WR_CYCLES(WRC)
  ) dut (
    .clk(clk), .rst(rst), .mac_busy_i(mac_busy), .rq(rq),
    .WL(wl), .PCH(pch), .WRITE(write), .WR_DATA(wr_data),
    .CSEL(csel), .SAEN(saen), .SA_OUT(sa_out)
  );

  always #5 clk = ~clk;

  // Behavioural macro: column-masked writes, sensed word only while SAEN.
  logic [NC-1:0] mem [NR];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int r = 0; r < int'(NR); r++) mem[r] <= '0;
    end else if (write) begin
      for (int r = 0; r < int'(NR); r++)
        if (wl[r]) mem[r] <= (mem[r] & ~csel) | (wr_data & csel);
    end
  end
  always_comb begin
    sa_out = 32'hDEAD_BEEF;
    if (saen)
      for (int r = 0; r < int'(NR); r++)
        if (wl[r]) sa_out = mem[r];
  end

  int n_rdv = 0;
  int n_acc = 0;
  always @(posedge clk) begin
    if (rq.rd_valid_o) n_rdv <= n_rdv + 1;
    if (!rst && rq.rq_valid_i && rq.rq_ready_o) n_acc <= n_acc + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] shadow [NR];
  logic [31:0] last_rd;

  task automatic chk_ctl(input string nm, input ctl_t act, input ctl_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  function automatic ctl_t sample();
    ctl_t c;
    c.wl = wl; c.pch = pch; c.write = write; c.wr_data = wr_data;
    c.csel = csel; c.saen = saen; c.rd_valid = rq.rd_valid_o;
    c.busy = rq.busy_o; c.ready = rq.rq_ready_o;
    return c;
  endfunction

  function automatic ctl_t exp_ctl(input ph_t ph, input logic [6:0] a,
                                   input logic [31:0] d, input logic mb);
    ctl_t e = '0;
    logic [NR-1:0] row = 128'(1) << a;
    case (ph)
      P_IDLE: e.ready = ~mb;
      P_WR:   begin e.wl = row; e.write = 1'b1; e.wr_data = d; e.csel = '1; e.busy = 1'b1; end
      P_REC:  e.busy = 1'b1;
      P_PCH:  begin e.pch = 1'b1; e.csel = '1; e.busy = 1'b1; end
      P_WL:   begin e.wl = row; e.csel = '1; e.busy = 1'b1; end
      P_SA:   begin e.wl = row; e.saen = 1'b1; e.csel = '1; e.busy = 1'b1; end
      P_RESP: begin e.rd_valid = 1'b1; e.busy = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accepting edge; checks every cycle of the access.
  task automatic run_sched(input bit wr, input logic [6:0] a, input logic [31:0] d,
                           input bit mb_mid, input logic [31:0] er);
    ph_t ph[$];
    if (wr) begin
      repeat (WRC) ph.push_back(P_WR);
      ph.push_back(P_REC);
    end else begin
      repeat (PCH) ph.push_back(P_PCH);
      repeat (WLC) ph.push_back(P_WL);
      repeat (SAC) ph.push_back(P_SA);
      ph.push_back(P_RESP);
    end
    for (int i = 0; i < ph.size(); i++) begin
      if (i > 0) tick();
      if (mb_mid && i == 1) mac_busy = 1'b1;
      #1;
      chk_ctl("ctl", sample(), exp_ctl(ph[i], a, d, mac_busy));
      if (ph[i] == P_RESP) chk_w("rd_data_resp", rq.rd_data_o, er);
    end
    tick();
    #1;
    chk_ctl("ctl_idle", sample(), exp_ctl(P_IDLE, a, d, mac_busy));
    chk_w("rd_data_hold", rq.rd_data_o, er);
    mac_busy = 1'b0;
    if (wr) shadow[a] = d;
    else last_rd = er;
  endtask

  task automatic do_txn(input bit wr, input logic [6:0] a, input logic [31:0] d,
                        input int mb_pre, input bit mb_mid, input logic [31:0] er);
    rq.rq_valid_i = 1'b1; rq.rq_wr_i = wr; rq.addr_i = a; rq.wr_data_i = d;
    if (mb_pre > 0) begin
      mac_busy = 1'b1;
      for (int k = 0; k < mb_pre; k++) begin
        #1;
        chk_ctl("mb_block", sample(), exp_ctl(P_IDLE, a, d, 1'b1));
        tick();
      end
      mac_busy = 1'b0;
    end
    #1;
    chk_w("ready_pre", 32'(rq.rq_ready_o), 32'(1));
    tick();
    rq.rq_valid_i = 1'b0;
    rq.rq_wr_i    = 1'($urandom);
    rq.addr_i     = 7'($urandom);
    rq.wr_data_i  = $urandom;
    run_sched(wr, a, d, mb_mid, wr ? last_rd : er);
  endtask

  vec_t tv [8];

  initial begin
    int acc0, rv0;
    ctl_t c;
    tv[0] = '{1'b1, 7'd5,   32'hA5A5_0F0F, 0, 1'b0, 32'h0};
    tv[1] = '{1'b0, 7'd5,   32'h0,         0, 1'b0, 32'hA5A5_0F0F};
    tv[2] = '{1'b1, 7'd127, 32'hFFFF_FFFF, 0, 1'b0, 32'h0};
    tv[3] = '{1'b0, 7'd127, 32'h0,         2, 1'b0, 32'hFFFF_FFFF};
    tv[4] = '{1'b1, 7'd0,   32'h1234_5678, 0, 1'b0, 32'h0};
    tv[5] = '{1'b0, 7'd0,   32'h0,         0, 1'b1, 32'h1234_5678};
    tv[6] = '{1'b0, 7'd64,  32'h0,         0, 1'b0, 32'h0};
    tv[7] = '{1'b0, 7'd5,   32'h0,         3, 1'b1, 32'hA5A5_0F0F};
    for (int r = 0; r < int'(NR); r++) shadow[r] = '0;
    last_rd = '0;

    // Reset held with a pending request: nothing may start.
    rst = 1'b1; mac_busy = 1'b0; mem_clr = 1'b1;
    rq.rq_valid_i = 1'b1; rq.rq_wr_i = 1'b1; rq.addr_i = 7'd3; rq.wr_data_i = 32'h1111_2222;
    repeat (3) tick();
    #1;
    c = sample(); c.ready = 1'b0;
    chk_ctl("rst_ctl", c, '0);
    chk_w("rst_rd_data", rq.rd_data_o, 32'h0);
    rq.rq_valid_i = 1'b0; mem_clr = 1'b0; rst = 1'b0;
    tick();
    #1;
    chk_ctl("post_rst", sample(), exp_ctl(P_IDLE, 7'd0, 32'h0, 1'b0));
    chk_w("post_rst_rd_data", rq.rd_data_o, 32'h0);
    chk_w("rst_no_accept", 32'(n_acc), 32'(0));

    for (int i = 0; i < 8; i++)
      do_txn(tv[i].wr, tv[i].a, tv[i].d, tv[i].mb_pre, tv[i].mb_mid, tv[i].exp_rd);

    // Back-to-back: read held valid through a write is taken on the first IDLE edge.
    acc0 = n_acc;
    rq.rq_valid_i = 1'b1; rq.rq_wr_i = 1'b1; rq.addr_i = 7'd9; rq.wr_data_i = 32'hC0FF_EE00;
    #1;
    chk_w("b2b_ready", 32'(rq.rq_ready_o), 32'(1));
    tick();
    rq.rq_wr_i = 1'b0; rq.wr_data_i = 32'h0;
    run_sched(1'b1, 7'd9, 32'hC0FF_EE00, 1'b0, last_rd);
    tick();
    rq.rq_valid_i = 1'b0;
    run_sched(1'b0, 7'd9, 32'h0, 1'b0, 32'hC0FF_EE00);
    chk_w("b2b_accepts", 32'(n_acc - acc0), 32'(2));

    // Reset during sensing aborts the read with no response.
    do_txn(1'b1, 7'd20, 32'h5555_AAAA, 0, 1'b0, 32'h0);
    rv0 = n_rdv;
    rq.rq_valid_i = 1'b1; rq.rq_wr_i = 1'b0; rq.addr_i = 7'd20;
    #1;
    tick();
    rq.rq_valid_i = 1'b0;
    repeat (PCH + WLC) tick();
    #1;
    chk_ctl("in_sa", sample(), exp_ctl(P_SA, 7'd20, 32'h0, 1'b0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_ctl("abort_ctl", sample(), exp_ctl(P_IDLE, 7'd0, 32'h0, 1'b0));
    chk_w("abort_rd_data", rq.rd_data_o, 32'h0);
    last_rd = '0;
    repeat (3) tick();
    chk_w("abort_no_rdv", 32'(n_rdv - rv0), 32'(0));
    do_txn(1'b0, 7'd20, 32'h0, 0, 1'b0, 32'h5555_AAAA);
    chk_w("abort_then_read", 32'(n_rdv - rv0), 32'(1));

    // Full-array sweep: data = row index.
    acc0 = n_acc; rv0 = n_rdv;
    for (int r = 0; r < int'(NR); r++) do_txn(1'b1, 7'(r), 32'(r), 0, 1'b0, 32'h0);
    for (int r = 0; r < int'(NR); r++) do_txn(1'b0, 7'(r), 32'h0, 0, 1'b0, 32'(r));
    chk_w("sweep_rdv", 32'(n_rdv - rv0), 32'(NR));
    chk_w("sweep_acc", 32'(n_acc - acc0), 32'(2 * NR));

    // Randomized traffic against the shadow memory.
    for (int i = 0; i < 300; i++) begin
      bit          wr = 1'($urandom_range(0, 1));
      logic [6:0]  a  = 7'($urandom);
      logic [31:0] d  = $urandom;
      int          mp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      bit          mm = ($urandom_range(0, 5) == 0);
      do_txn(wr, a, d, mp, mm, shadow[a]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within 1000000 time units");
    $fatal(1);
  end

endmodule

// File: doc/sram_rq_responder.md
# sram_rq_responder

Responder side of the `sram_itf` request channel. It accepts single-word read/write requests (`rq_valid`/`rq_ready`, `rq_wr`, `addr`, `wr_data`) and sequences the analog SRAM macro controls (`WL`, `PCH`, `WRITE`, `WR_DATA`, `CSEL`, `SAEN`). It captures `SA_OUT` on reads and returns the word with a one-cycle `rd_valid` pulse. It sits inside the accelerator between the `sram_itf` port and the `to_analog`/`from_analog` bundles, and is locked out while the macro is in MAC mode.

## Interface

Parameters:
- `numRows`, 128, SRAM rows; address width `AW = $clog2(numRows)`
- `numCols`, 32, SRAM columns, which is also the data word width
- `PCH_CYCLES`, 2, bitline precharge duration for reads (≥1)
- `WL_CYCLES`, 1, wordline-only duration before sensing (≥1)
- `SA_CYCLES`, 2, sense-amp enable duration (≥1)
- `WR_CYCLES`, 2, write pulse duration (≥1)

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `mac_busy_i`  in  1  macro is in MAC mode; blocks acceptance of new requests
- `rq_valid_i`  in  1  request valid
- `rq_wr_i`  in  1  1 = write, 0 = read
- `addr_i`  in  AW  row address
- `wr_data_i`  in  numCols  write data
- `rq_ready_o`  out  1  request can be accepted this cycle
- `rd_valid_o`  out  1  one-cycle pulse; `rd_data_o` is valid
- `rd_data_o`  out  numCols  last read word
- `busy_o`  out  1  an access is in progress (state ≠ IDLE)
- `WL`  out  numRows  one-hot wordline
- `PCH`  out  1  bitline precharge, active-high
- `WRITE`  out  1  write driver enable
- `WR_DATA`  out  numCols  column write data
- `CSEL`  out  numCols  column select
- `SAEN`  out  1  sense-amp enable
- `SA_OUT`  in  numCols  sense-amp outputs

## Operation

- FSM states and outputs:
  - IDLE: all macro controls low.
  - WR: `WL[a]=1`, `WRITE=1`, `WR_DATA=d`, `CSEL` all ones.
  - WR_REC: all macro controls low.
  - RD_PCH: `PCH=1`, `CSEL` all ones.
  - RD_WL: `WL[a]=1`, `CSEL` all ones.
  - RD_SA: `WL[a]=1`, `SAEN=1`, `CSEL` all ones.
  - RD_RESP: all macro controls low; `rd_valid_o=1`.
- Macro controls are a Moore decode of the registered state plus the latched address and data (`a`, `d`). No control depends on a request input.
- `rq_ready_o = (state==IDLE) & !mac_busy_i`.
- Accept occurs on a rising edge where `rq_valid_i & rq_ready_o` is true. On accept, latch `addr_i`, `wr_data_i` and `rq_wr_i`.
  - Write → WR.
  - Read → RD_PCH.
- Transitions:
  - WR lasts WR_CYCLES, then WR_REC for 1 cycle, then IDLE.
  - RD_PCH lasts PCH_CYCLES, then RD_WL for WL_CYCLES, then RD_SA for SA_CYCLES, then RD_RESP for 1 cycle, then IDLE.
  - A single down-counter, loaded on each state entry, times the states.
- Read capture: on the edge that leaves the last RD_SA cycle, `rd_data_o <= SA_OUT`. `rd_data_o` holds until the next read capture; writes do not change it.
- `WL` is never asserted in the same cycle as `PCH`. `WRITE` and `SAEN` are never asserted together.
- If `addr_i >= numRows` (non-power-of-2 `numRows`), the request is still accepted and sequenced, but `WL` stays all-zero. A read of such an address returns 0.
- `mac_busy_i` asserting mid-access has no effect on the access, which runs to completion. It only gates acceptance.
- Requests arriving while busy are not accepted and not queued. The initiator holds `rq_valid_i` until it is accepted.

## Timing

- Reset (`rst=1` at an edge): state → IDLE, counter → 0, latches → 0, `rd_data_o` → 0. After that edge, every output is 0 except `rq_ready_o`, which equals `!mac_busy_i` once `rst` is low.
- Reset mid-access aborts the access. All macro controls are low in the cycle after the reset edge. No `rd_valid_o` is produced for the aborted read.
- Let accept be edge E0. Write:
  - WR spans E0 to E0+WR_CYCLES.
  - `rq_ready_o` returns at E0+WR_CYCLES+1.
  - Defaults: ready again 3 cycles after accept.
- Let accept be edge E0. Read:
  - `rd_valid_o` is high during the cycle starting at E0+PCH_CYCLES+WL_CYCLES+SA_CYCLES. Defaults: 5 cycles after accept.
  - `rq_ready_o` returns one cycle later (E0+6 with defaults).
- `rq_ready_o` is low in the cycle after any accept, so an initiator that drops valid one cycle after accept gets exactly one access.
- Back-to-back: a request held valid is accepted on the first edge where the FSM is in IDLE. There are no idle bubbles beyond WR_REC/RD_RESP.

## Test plan

- Reset with `rq_valid_i=1` → no accept while `rst=1`. After release: `rq_ready_o=1`, `WL=0`, `rd_data_o=0`, `rd_valid_o=0`.
- Write addr 5, data 0xA5A5_0F0F (defaults) → `WL=1<<5`, `WRITE=1`, `WR_DATA=0xA5A50F0F` for exactly 2 cycles, then 1 idle-control cycle. `rq_ready_o` returns 3 cycles after accept.
- Read addr 5, with the macro model returning 0xA5A5_0F0F → 2 cycles `PCH=1`, then 1 cycle `WL`, then 2 cycles `WL+SAEN`. `rd_valid_o` pulses once, 5 cycles after accept, with `rd_data_o=0xA5A50F0F`; the value holds afterward.
- Write all 128 rows with `data=row`, then read all 128 back → every read returns its row index. Exactly 128 `rd_valid_o` pulses, and no double accepts.
- `mac_busy_i=1` with `rq_valid_i` held → `rq_ready_o=0` and no access. Drop `mac_busy_i` → accept on the next edge. Raising `mac_busy_i` mid-read → the read still completes with its data.
- Assert `rst` during RD_SA → controls are 0 the next cycle, no `rd_valid_o`, and `rd_data_o=0`. A following read completes normally.
